tcp_hdr_chksum_fill: RTL and testbench
======================================

// Module: tcp_hdr_chksum_fill
// PURPOSE
//   Sits directly downstream of the TCP header assembler on the transmit path and consumes
//   its tcp_pkt_hdr.
//   Computes the RFC 793 TCP checksum over the IPv4 pseudo-header plus the 20-byte TCP header.
//   Payload contribution arrives as a precomputed 16-bit one's-complement partial sum.
//   Emits the same header with chksum filled to the IP/packet assembly stage.
//   Multi-cycle iterative adder: trades latency for area.
// PARAMETERS
//   ADDS_PER_CYCLE  4  16-bit words summed per SUM cycle; legal values 1,2,4,8,16 (must divide 16)
// PORTS
//   clk                  in   1                clock
//   rst                  in   1                reset, asynchronous, active-high
//   in_tcp_hdr_val       in   1                request valid
//   in_tcp_hdr_rdy       out  1                block can accept request
//   in_tcp_hdr           in   tcp_pkt_hdr      header from assembler; incoming chksum field ignored
//   in_src_ip            in   `IP_ADDR_W       pseudo-header source IPv4 address
//   in_dst_ip            in   `IP_ADDR_W       pseudo-header destination IPv4 address
//   in_tcp_len           in   `TOT_LEN_W       TCP segment bytes (header + payload)
//   in_payload_chksum    in   16               one's-complement sum of payload (0 if none)
//   out_tcp_hdr_val      out  1                result valid
//   out_tcp_hdr_rdy      in   1                downstream accepts
//   out_tcp_hdr          out  tcp_pkt_hdr      captured header with chksum written
// BEHAVIOUR
//   Reset values: in_tcp_hdr_rdy=0 during reset, 1 the first cycle after;
//     out_tcp_hdr_val=0; out_tcp_hdr='0; accumulator=0; state=IDLE.
//   FSM IDLE -> SUM -> FOLD -> OUT -> IDLE.
//   IDLE: rdy=1. On val&rdy:
//     - register hdr (chksum forced 0), src/dst IP, tcp_len, payload_chksum;
//     - acc <= payload_chksum; word index <= 0; go to SUM.
//   SUM: each cycle add ADDS_PER_CYCLE words to acc; advance index by ADDS_PER_CYCLE.
//     After index reaches 16 (16/ADDS_PER_CYCLE cycles), go to FOLD.
//   Word order (16 words), all MSB-first:
//     - src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0], 16'h0006, tcp_len;
//     - then the 160-bit packed tcp_pkt_hdr split into 10 words with chksum=0.
//   Width rules: acc 21 bits (16 words + partial, max < 2^21; carries are never lost).
//   FOLD (one cycle): s = acc[15:0]+acc[20:16]; s = s[15:0]+s[16]; chksum = ~s[15:0].
//     A fold result of 16'hFFFF gives chksum 16'h0000; this value is sent as-is (no
//     0->FFFF substitution for TCP). Write chksum into the header register; go to OUT.
//   OUT: out_val=1, data stable until out_val&out_rdy; then -> IDLE, out_val drops next cycle.
//   Latency: accept at cycle T -> out_val at T+16/ADDS_PER_CYCLE+2 (ADDS=4: T+6).
//   Throughput: one header per 16/ADDS+3 cycles; no overlap.
//   in_rdy=0 in SUM/FOLD/OUT; upstream holds val (its val/rdy is combinational pass-through).
//   Backpressure: OUT held indefinitely without corruption or re-summing.
//   in_val while busy: ignored, not lost (upstream holds it).
//   Reset mid-operation: in-flight header discarded, out_val=0 immediately (async), no output.
//   No combinational path in_* -> out_*; out_rdy does not affect in_rdy combinationally.
// STRUCTURE
//   packet_struct_pkg (existing): tcp_pkt_hdr, TCP_HDR_BYTES.
//   Add to packet_struct_pkg: localparam IP_PROTO_TCP=8'd6; TCP_PSEUDO_HDR_BYTES=12.
//   Sub-module ones_comp_adder_tree #(N_WORDS=ADDS_PER_CYCLE): combinational sum of N
//     16-bit words into a 21-bit result; reusable by the IP header checksum stage.
//   Word-select mux and FSM live in this module.
// TESTING
//   1. IPs=0, hdr all zero except raw_data_offset=5, tcp_len=20, payload=0 -> chksum 16'hAFE5.
//   2. Same but src_ip=dst_ip=32'hFFFFFFFF -> end-around carries folded, chksum 16'hAFE5.
//   3. As test 1 with payload_chksum=16'hAFE5 -> sum 16'hFFFF -> chksum 16'h0000 emitted.
//   4. out_rdy low 10 cycles in OUT, in_val held with new hdr ->
//      - out data stable, in_rdy=0 throughout;
//      - second header accepted the cycle after the output handshake.
//   5. Back-to-back requests, out_rdy=1, ADDS_PER_CYCLE=1/4/16 ->
//      - latency 18/6/3 cycles;
//      - results match reference model on 1000 random headers.
//   6. Assert rst during SUM -> out_val=0 same cycle; after release, a fresh request
//      gives the correct checksum (no stale acc).

Source files
------------

// File: rtl/packet_struct_pkg.sv
// Shared packet field layouts and checksum constants for the transmit path.
// Also holds the final fold step so the IP header checksum stage can reuse it.
package packet_struct_pkg;

  localparam int IP_ADDR_W            = 32;
  localparam int TOT_LEN_W            = 16;
  localparam int TCP_HDR_BYTES        = 20;
  localparam int TCP_HDR_W            = TCP_HDR_BYTES * 8;
  localparam int TCP_PSEUDO_HDR_BYTES = 12;
  localparam logic [7:0] IP_PROTO_TCP = 8'd6;

  // Pseudo-header plus TCP header, in 16-bit words.
  localparam int CHKSUM_WORDS = (TCP_PSEUDO_HDR_BYTES + TCP_HDR_BYTES) / 2;
  localparam int CHKSUM_ACC_W = 21;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  raw_data_offset;
    logic [3:0]  reserved;
    logic [7:0]  flags;
    logic [15:0] window;
    logic [15:0] chksum;
    logic [15:0] urg_ptr;
  } tcp_pkt_hdr;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_FOLD,
    ST_OUT
  } chk_state_e;

  // Two end-around-carry folds bring any 21-bit sum into 16 bits; then invert.
  function automatic logic [15:0] fold_chksum(input logic [CHKSUM_ACC_W-1:0] acc);
    logic [16:0] s;
    s = {1'b0, acc[15:0]} + {12'd0, acc[CHKSUM_ACC_W-1:16]};
    s = {1'b0, s[15:0]} + {16'd0, s[16]};
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/ones_comp_adder_tree.sv
// Combinational sum of N 16-bit words into a wide accumulator-sized result.
// Carries are kept, not folded, so the caller decides when to fold.
module ones_comp_adder_tree
  import packet_struct_pkg::*;
#(
  parameter int N_WORDS = 4
) (
  input  logic [N_WORDS*16-1:0]    words,
  output logic [CHKSUM_ACC_W-1:0]  sum
);

  // NOTE: combinational logic uses blocking '=' and assigns every output first,
  // so the loop reads as a running sum and no latch can be inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      sum = sum + CHKSUM_ACC_W'(words[i*16 +: 16]);
    end
  end

endmodule

// File: rtl/tcp_hdr_chksum_fill.sv
// Fills the TCP checksum over IPv4 pseudo-header + 20-byte header + payload partial sum.
// Iterative: ADDS_PER_CYCLE words per cycle, then a one-cycle fold, then a held output.
module tcp_hdr_chksum_fill
  import packet_struct_pkg::*;
#(
  parameter int ADDS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_tcp_hdr_val,
  output logic                  in_tcp_hdr_rdy,
  input  tcp_pkt_hdr            in_tcp_hdr,
  input  logic [IP_ADDR_W-1:0]  in_src_ip,
  input  logic [IP_ADDR_W-1:0]  in_dst_ip,
  input  logic [TOT_LEN_W-1:0]  in_tcp_len,
  input  logic [15:0]           in_payload_chksum,
  output logic                  out_tcp_hdr_val,
  input  logic                  out_tcp_hdr_rdy,
  output tcp_pkt_hdr            out_tcp_hdr
);

  localparam int IDX_W     = $clog2(CHKSUM_WORDS) + 1;
  localparam int HDR_WORDS = TCP_HDR_BYTES / 2;

  chk_state_e               state;
  logic [IP_ADDR_W-1:0]     src_q;
  logic [IP_ADDR_W-1:0]     dst_q;
  logic [TOT_LEN_W-1:0]     len_q;
  logic [CHKSUM_ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         idx_nxt;

  tcp_pkt_hdr               hdr_clr;
  logic [TCP_HDR_W-1:0]     hdr_bits;
  logic [15:0]              words [CHKSUM_WORDS];
  logic [IDX_W-2:0]         widx;
  logic [ADDS_PER_CYCLE*16-1:0] sel_words;
  logic [CHKSUM_ACC_W-1:0]  tree_sum;

  always_comb begin
    hdr_clr        = in_tcp_hdr;
    hdr_clr.chksum = '0;
  end

  // The header register doubles as the output; its chksum is zero until FOLD.
  assign hdr_bits = out_tcp_hdr;
  assign idx_nxt  = idx + IDX_W'(ADDS_PER_CYCLE);

  always_comb begin
    words[0] = src_q[31:16];
    words[1] = src_q[15:0];
    words[2] = dst_q[31:16];
    words[3] = dst_q[15:0];
    words[4] = {8'd0, IP_PROTO_TCP};
    words[5] = len_q;
    for (int i = 0; i < HDR_WORDS; i++) begin
      words[6+i] = hdr_bits[TCP_HDR_W-1-16*i -: 16];
    end
  end

  always_comb begin
    sel_words = '0;
    widx      = '0;
    for (int i = 0; i < ADDS_PER_CYCLE; i++) begin
      widx = idx[IDX_W-2:0] + (IDX_W-1)'(i);
      sel_words[i*16 +: 16] = words[widx];
    end
  end

  ones_comp_adder_tree #(
    .N_WORDS (ADDS_PER_CYCLE)
  ) u_adder (
    .words (sel_words),
    .sum   (tree_sum)
  );

  // NOTE: registers use non-blocking '<=' so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      in_tcp_hdr_rdy  <= 1'b0;
      out_tcp_hdr_val <= 1'b0;
      out_tcp_hdr     <= '0;
      src_q           <= '0;
      dst_q           <= '0;
      len_q           <= '0;
      acc             <= '0;
      idx             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_tcp_hdr_rdy <= 1'b1;
          if (in_tcp_hdr_val && in_tcp_hdr_rdy) begin
            out_tcp_hdr    <= hdr_clr;
            src_q          <= in_src_ip;
            dst_q          <= in_dst_ip;
            len_q          <= in_tcp_len;
            acc            <= {{(CHKSUM_ACC_W-16){1'b0}}, in_payload_chksum};
            idx            <= '0;
            in_tcp_hdr_rdy <= 1'b0;
            state          <= ST_SUM;
          end
        end
        ST_SUM: begin
          acc <= acc + tree_sum;
          idx <= idx_nxt;
          if (idx_nxt == IDX_W'(CHKSUM_WORDS)) state <= ST_FOLD;
        end
        ST_FOLD: begin
          // A fold of 16'hFFFF yields 16'h0000 and is sent unchanged.
          out_tcp_hdr.chksum <= fold_chksum(acc);
          out_tcp_hdr_val    <= 1'b1;
          state              <= ST_OUT;
        end
        ST_OUT: begin
          if (out_tcp_hdr_rdy) begin
            out_tcp_hdr_val <= 1'b0;
            in_tcp_hdr_rdy  <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_hdr_chksum_fill.sv
// Directed and random checks of tcp_hdr_chksum_fill with a queue-based scoreboard.
// Extra instances with 1 and 16 adds per cycle cover the latency range.
module tb_tcp_hdr_chksum_fill;
  import packet_struct_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_val  = 1'b0;
  logic        out_rdy = 1'b1;
  logic        in_rdy;
  logic        out_val;
  tcp_pkt_hdr  in_hdr  = '0;
  tcp_pkt_hdr  out_hdr;
  logic [31:0] src_ip  = '0;
  logic [31:0] dst_ip  = '0;
  logic [15:0] tcp_len = '0;
  logic [15:0] pay     = '0;

  logic        val1 = 1'b0;
  logic        rdy1;
  logic        oval1;
  tcp_pkt_hdr  ohdr1;
  logic        val16 = 1'b0;
  logic        rdy16;
  logic        oval16;
  tcp_pkt_hdr  ohdr16;

  tcp_hdr_chksum_fill #(.ADDS_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst),
    .in_tcp_hdr_val(in_val), .in_tcp_hdr_rdy(in_rdy), .in_tcp_hdr(in_hdr),
    .in_src_ip(src_ip), .in_dst_ip(dst_ip), .in_tcp_len(tcp_len),
    .in_payload_chksum(pay),
    .out_tcp_hdr_val(out_val), .out_tcp_hdr_rdy(out_rdy), .out_tcp_hdr(out_hdr)
  );

  tcp_hdr_chksum_fill #(.ADDS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_tcp_hdr_val(val1), .in_tcp_hdr_rdy(rdy1), .in_tcp_hdr(in_hdr),
    .in_src_ip(src_ip), .in_dst_ip(dst_ip), .in_tcp_len(tcp_len),
    .in_payload_chksum(pay),
    .out_tcp_hdr_val(oval1), .out_tcp_hdr_rdy(1'b1), .out_tcp_hdr(ohdr1)
  );

  tcp_hdr_chksum_fill #(.ADDS_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_tcp_hdr_val(val16), .in_tcp_hdr_rdy(rdy16), .in_tcp_hdr(in_hdr),
    .in_src_ip(src_ip), .in_dst_ip(dst_ip), .in_tcp_len(tcp_len),
    .in_payload_chksum(pay),
    .out_tcp_hdr_val(oval16), .out_tcp_hdr_rdy(1'b1), .out_tcp_hdr(ohdr16)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  tcp_pkt_hdr sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: 32-bit running sum, folded until no carry remains.
  function automatic logic [15:0] ref_chksum(input tcp_pkt_hdr h, input logic [31:0] s,
                                             input logic [31:0] d, input logic [15:0] len,
                                             input logic [15:0] p);
    logic [159:0] b;
    logic [31:0]  sum;
    h.chksum = '0;
    b   = h;
    sum = {16'd0, p} + {16'd0, s[31:16]} + {16'd0, s[15:0]} + {16'd0, d[31:16]}
        + {16'd0, d[15:0]} + 32'd6 + {16'd0, len};
    for (int i = 0; i < 10; i++) sum = sum + {16'd0, b[16*i +: 16]};
    while (sum[31:16] != 16'd0) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    return ~sum[15:0];
  endfunction

  function automatic tcp_pkt_hdr rand_hdr();
    logic [159:0] b;
    for (int i = 0; i < 5; i++) b[32*i +: 32] = $urandom;
    return tcp_pkt_hdr'(b);
  endfunction

  // Output side of the scoreboard: compare on every output handshake.
  always @(negedge clk) begin
    tcp_pkt_hdr exp_hdr;
    if (!rst && out_val && out_rdy) begin
      if (sb.size() == 0) check("unexpected_out", 160'(out_val), 160'd0);
      else begin
        exp_hdr = sb.pop_front();
        check("out_hdr", out_hdr, exp_hdr);
      end
    end
  end

  task automatic send(input tcp_pkt_hdr h, input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] len, input logic [15:0] p, input logic [15:0] ck,
                      output int acc_cyc);
    tcp_pkt_hdr e;
    int n;
    @(negedge clk);
    in_hdr = h; src_ip = s; dst_ip = d; tcp_len = len; pay = p; in_val = 1'b1;
    n = 0;
    while (!in_rdy && n < 200) begin @(negedge clk); n++; end
    check("accept_timeout", 160'(in_rdy), 160'd1);
    acc_cyc  = cyc;
    e        = h;
    e.chksum = ck;
    sb.push_back(e);
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("drain_timeout", 160'(sb.size()), 160'd0);
  endtask

  initial begin
    tcp_pkt_hdr  hdr0, h, hb, held, e;
    logic [31:0] s, d;
    logic [15:0] l, p, ck1, ck16;
    int          a, prev, lat4, lat1, lat16, n;

    // Reset state
    #2;
    check("rst_in_rdy", 160'(in_rdy), 160'd0);
    check("rst_out_val", 160'(out_val), 160'd0);
    check("rst_out_hdr", out_hdr, 160'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_rdy_after_rst", 160'(in_rdy), 160'd1);

    // Test 1 on all three widths at once: value and latency
    hdr0 = '0;
    hdr0.raw_data_offset = 4'd5;
    in_hdr = hdr0; src_ip = '0; dst_ip = '0; tcp_len = 16'd20; pay = '0;
    in_val = 1'b1; val1 = 1'b1; val16 = 1'b1;
    check("rdy1_idle", 160'(rdy1), 160'd1);
    check("rdy16_idle", 160'(rdy16), 160'd1);
    e = hdr0; e.chksum = 16'hAFE5; sb.push_back(e);
    @(posedge clk); #1;
    in_val = 1'b0; val1 = 1'b0; val16 = 1'b0;
    lat4 = -1; lat1 = -1; lat16 = -1; ck1 = '0; ck16 = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (out_val && lat4 < 0) lat4 = k;
      if (oval1 && lat1 < 0) begin lat1 = k; ck1 = ohdr1.chksum; end
      if (oval16 && lat16 < 0) begin lat16 = k; ck16 = ohdr16.chksum; end
    end
    check("latency_adds4", 160'(lat4), 160'd6);
    check("latency_adds1", 160'(lat1), 160'd18);
    check("latency_adds16", 160'(lat16), 160'd3);
    check("chksum_adds1", 160'(ck1), 160'hAFE5);
    check("chksum_adds16", 160'(ck16), 160'hAFE5);
    wait_drain();

    // Test 2: all-ones addresses force end-around carries
    send(hdr0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd20, 16'd0, 16'hAFE5, a);
    // Test 3: sum of 16'hFFFF emits 16'h0000
    send(hdr0, 32'd0, 32'd0, 16'd20, 16'hAFE5, 16'h0000, a);
    // Incoming chksum field is ignored
    h = hdr0; h.chksum = 16'h1234;
    send(h, 32'd0, 32'd0, 16'd20, 16'd0, 16'hAFE5, a);
    wait_drain();

    // Test 4: backpressure with the next request held
    @(posedge clk); #1;
    out_rdy = 1'b0;
    h = rand_hdr(); s = $urandom; d = $urandom; l = 16'($urandom); p = 16'($urandom);
    send(h, s, d, l, p, ref_chksum(h, s, d, l, p), a);
    hb = rand_hdr(); s = $urandom; d = $urandom; l = 16'($urandom); p = 16'($urandom);
    @(negedge clk);
    in_hdr = hb; src_ip = s; dst_ip = d; tcp_len = l; pay = p; in_val = 1'b1;
    n = 0;
    while (!out_val && n < 50) begin @(negedge clk); n++; end
    check("bp_out_timeout", 160'(out_val), 160'd1);
    held = out_hdr;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hdr_stable", out_hdr, held);
      check("bp_out_val_held", 160'(out_val), 160'd1);
      check("bp_in_rdy_low", 160'(in_rdy), 160'd0);
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("accept_after_handshake", 160'(in_rdy), 160'd1);
    e = hb; e.chksum = ref_chksum(hb, s, d, l, p); sb.push_back(e);
    @(posedge clk); #1;
    in_val = 1'b0;
    wait_drain();

    // Test 5: back-to-back random headers, one accept every 7 cycles
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      h = rand_hdr(); s = $urandom; d = $urandom; l = 16'($urandom); p = 16'($urandom);
      send(h, s, d, l, p, ref_chksum(h, s, d, l, p), a);
      if (i > 0) check("throughput", 160'(a - prev), 160'd7);
      prev = a;
    end
    wait_drain();

    // Test 6: reset during SUM discards the request
    send(rand_hdr(), $urandom, $urandom, 16'd40, 16'd0, 16'h0000, a);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_sum_out_val", 160'(out_val), 160'd0);
    check("rst_sum_in_rdy", 160'(in_rdy), 160'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("no_stale_out", 160'(out_val), 160'd0);
    end
    send(hdr0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd20, 16'd0, 16'hAFE5, a);
    wait_drain();

    // Reset while holding an output clears it asynchronously
    @(posedge clk); #1;
    out_rdy = 1'b0;
    h = rand_hdr();
    send(h, 32'd1, 32'd2, 16'd20, 16'd0, ref_chksum(h, 32'd1, 32'd2, 16'd20, 16'd0), a);
    n = 0;
    while (!out_val && n < 50) begin @(negedge clk); n++; end
    check("out_wait_timeout", 160'(out_val), 160'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_out_async_val", 160'(out_val), 160'd0);
    check("rst_out_async_hdr", out_hdr, 160'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_rdy = 1'b1;
    send(hdr0, 32'd0, 32'd0, 16'd20, 16'd0, 16'hAFE5, a);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
